// File: rtl/obi_demux_1_to_2.sv
// rtl/obi_demux_1_to_2.sv - OBI 1-to-2 address demultiplexer with error sink and one outstanding read.
// Optional read watchdog enabled by defining OBI_DEMUX_TIMEOUT_EN.
module obi_demux_1_to_2 #(
    parameter logic [31:0] S0_BASE        = 32'h0000_0000,
    parameter logic [31:0] S0_MASK        = 32'hFFFF_0000,
    parameter logic [31:0] S1_BASE        = 32'h1000_0000,
    parameter logic [31:0] S1_MASK        = 32'hFFFF_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mst_req_i,
    output logic        mst_gnt_o,
    input  logic [31:0] mst_addr_i,
    input  logic        mst_we_i,
    input  logic [3:0]  mst_be_i,
    input  logic [31:0] mst_wdata_i,
    output logic        mst_rvalid_o,
    output logic [31:0] mst_rdata_o,
    output logic        s0_req_o,
    input  logic        s0_gnt_i,
    output logic [31:0] s0_addr_o,
    output logic        s0_we_o,
    output logic [3:0]  s0_be_o,
    output logic [31:0] s0_wdata_o,
    input  logic        s0_rvalid_i,
    input  logic [31:0] s0_rdata_i,
    output logic        s1_req_o,
    input  logic        s1_gnt_i,
    output logic [31:0] s1_addr_o,
    output logic        s1_we_o,
    output logic [3:0]  s1_be_o,
    output logic [31:0] s1_wdata_o,
    input  logic        s1_rvalid_i,
    input  logic [31:0] s1_rdata_i,
    output logic        decode_err_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {IDLE, WAIT0, WAIT1, ERR} state_t;

    state_t state_q, state_d;

    logic hit0, hit1, miss;
    logic in_wait, sel_rvalid, avail, accept_rd, to_fire;

    assign hit0 = ((mst_addr_i & S0_MASK) == S0_BASE);
    assign hit1 = ((mst_addr_i & S1_MASK) == S1_BASE) & ~hit0;
    assign miss = ~hit0 & ~hit1;

    assign s0_addr_o  = mst_addr_i;
    assign s0_we_o    = mst_we_i;
    assign s0_be_o    = mst_be_i;
    assign s0_wdata_o = mst_wdata_i;
    assign s1_addr_o  = mst_addr_i;
    assign s1_we_o    = mst_we_i;
    assign s1_be_o    = mst_be_i;
    assign s1_wdata_o = mst_wdata_i;

    assign in_wait    = (state_q == WAIT0) || (state_q == WAIT1);
    assign sel_rvalid = ((state_q == WAIT0) & s0_rvalid_i) | ((state_q == WAIT1) & s1_rvalid_i);

    // Gating with rst_ni keeps the upstream quiet while reset is held, not just after an edge.
    always_comb begin
        avail = 1'b0;
        case (state_q)
            IDLE, ERR: avail = 1'b1;
            default:   avail = sel_rvalid;
        endcase
        avail = avail & rst_ni;
    end

    assign s0_req_o  = mst_req_i & hit0 & avail;
    assign s1_req_o  = mst_req_i & hit1 & avail;
    assign mst_gnt_o = avail & ((hit0 & s0_gnt_i) | (hit1 & s1_gnt_i) | (miss & mst_req_i));
    assign accept_rd = mst_req_i & mst_gnt_o & ~mst_we_i;

`ifdef OBI_DEMUX_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (in_wait && !sel_rvalid) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (accept_rd && !miss) begin
            cnt_d = 8'd0;
        end
    end

    assign to_fire = rst_ni & in_wait & ~sel_rvalid & (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    assign to_fire = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mst_rvalid_o = 1'b0;
        mst_rdata_o  = 32'h0;
        decode_err_o = 1'b0;
        timeout_o    = 1'b0;

        if (to_fire) begin
            state_d = IDLE;
        end else if (avail) begin
            if (accept_rd) begin
                if (hit0)      state_d = WAIT0;
                else if (hit1) state_d = WAIT1;
                else           state_d = ERR;
            end else begin
                state_d = IDLE;
            end
        end

        if (rst_ni) begin
            case (state_q)
                WAIT0: begin
                    mst_rvalid_o = s0_rvalid_i;
                    mst_rdata_o  = s0_rdata_i;
                end
                WAIT1: begin
                    mst_rvalid_o = s1_rvalid_i;
                    mst_rdata_o  = s1_rdata_i;
                end
                ERR: begin
                    mst_rvalid_o = 1'b1;
                    decode_err_o = 1'b1;
                end
                default: ;
            endcase
            if (to_fire) begin
                mst_rvalid_o = 1'b1;
                mst_rdata_o  = 32'hBAD0_0BAD;
                timeout_o    = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_obi_demux_1_to_2.sv
// tb/tb_obi_demux_1_to_2.sv - directed self-checking bench for obi_demux_1_to_2.
module tb_obi_demux_1_to_2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mst_req = 1'b0, mst_gnt, mst_we = 1'b0;
    logic [31:0] mst_addr = 32'h0, mst_wdata = 32'h0, mst_rdata;
    logic [3:0]  mst_be = 4'hF;
    logic        mst_rvalid;
    logic        s0_req, s0_gnt = 1'b0, s0_we, s0_rvalid = 1'b0;
    logic [31:0] s0_addr, s0_wdata, s0_rdata = 32'h0;
    logic [3:0]  s0_be;
    logic        s1_req, s1_gnt = 1'b0, s1_we, s1_rvalid = 1'b0;
    logic [31:0] s1_addr, s1_wdata, s1_rdata = 32'h0;
    logic [3:0]  s1_be;
    logic        decode_err, timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    obi_demux_1_to_2 dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mst_req_i(mst_req), .mst_gnt_o(mst_gnt), .mst_addr_i(mst_addr), .mst_we_i(mst_we),
        .mst_be_i(mst_be), .mst_wdata_i(mst_wdata), .mst_rvalid_o(mst_rvalid), .mst_rdata_o(mst_rdata),
        .s0_req_o(s0_req), .s0_gnt_i(s0_gnt), .s0_addr_o(s0_addr), .s0_we_o(s0_we), .s0_be_o(s0_be),
        .s0_wdata_o(s0_wdata), .s0_rvalid_i(s0_rvalid), .s0_rdata_i(s0_rdata),
        .s1_req_o(s1_req), .s1_gnt_i(s1_gnt), .s1_addr_o(s1_addr), .s1_we_o(s1_we), .s1_be_o(s1_be),
        .s1_wdata_o(s1_wdata), .s1_rvalid_i(s1_rvalid), .s1_rdata_i(s1_rdata),
        .decode_err_o(decode_err), .timeout_o(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 2ns later, 3ns before the rising edge.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        // reset held: outputs quiet even with a live request
        mst_req = 1'b1; mst_addr = 32'h0000_0010; s0_gnt = 1'b1;
        step(); #2;
        chk("rst_gnt", mst_gnt, 0);
        chk("rst_s0_req", s0_req, 0);
        chk("rst_s1_req", s1_req, 0);
        chk("rst_rvalid", mst_rvalid, 0);
        chk("rst_rdata", mst_rdata, 0);
        chk("rst_derr", decode_err, 0);
        chk("rst_tmo", timeout, 0);

        // read to s0, response 3 cycles after grant, s1 rvalid ignored
        step(); rst_n = 1'b1; #2;
        chk("r0_s0_req", s0_req, 1);
        chk("r0_s1_req", s1_req, 0);
        chk("r0_gnt", mst_gnt, 1);
        chk("r0_bcast_addr", s1_addr, 32'h0000_0010);
        step(); mst_req = 1'b0; s1_rvalid = 1'b1; s1_rdata = 32'hDEAD_BEEF; #2;
        chk("r0_w1_rvalid", mst_rvalid, 0);
        chk("r0_w1_gnt", mst_gnt, 0);
        step(); s1_rvalid = 1'b0; #2;
        chk("r0_w2_rvalid", mst_rvalid, 0);
        chk("r0_w2_s1_req", s1_req, 0);
        step(); s0_rvalid = 1'b1; s0_rdata = 32'h1234_5678; #2;
        chk("r0_rvalid", mst_rvalid, 1);
        chk("r0_rdata", mst_rdata, 32'h1234_5678);
        step(); s0_rvalid = 1'b0; #2;
        chk("r0_idle_rvalid", mst_rvalid, 0);
        chk("r0_idle_rdata", mst_rdata, 0);

        // read to s1 with grant delayed two cycles
        s0_gnt = 1'b0;
        step(); mst_req = 1'b1; mst_addr = 32'h1000_0004; s1_gnt = 1'b0; #2;
        chk("r1_c0_gnt", mst_gnt, 0);
        chk("r1_c0_s1_req", s1_req, 1);
        chk("r1_c0_s0_req", s0_req, 0);
        step(); #2;
        chk("r1_c1_gnt", mst_gnt, 0);
        chk("r1_c1_s1_req", s1_req, 1);
        step(); s1_gnt = 1'b1; #2;
        chk("r1_c2_gnt", mst_gnt, 1);
        step(); mst_req = 1'b0; s1_rvalid = 1'b1; s1_rdata = 32'hCAFE_BABE; #2;
        chk("r1_rvalid", mst_rvalid, 1);
        chk("r1_rdata", mst_rdata, 32'hCAFE_BABE);
        step(); s1_rvalid = 1'b0; s1_gnt = 1'b0; #2;
        chk("r1_idle_rvalid", mst_rvalid, 0);

        // unmapped read: immediate grant, one-cycle zero response with decode error
        step(); mst_req = 1'b1; mst_addr = 32'h2000_0000; #2;
        chk("err_gnt", mst_gnt, 1);
        chk("err_s0_req", s0_req, 0);
        chk("err_s1_req", s1_req, 0);
        step(); mst_req = 1'b0; #2;
        chk("err_rvalid", mst_rvalid, 1);
        chk("err_rdata", mst_rdata, 0);
        chk("err_derr", decode_err, 1);
        step(); #2;
        chk("err_after_rvalid", mst_rvalid, 0);
        chk("err_after_derr", decode_err, 0);

        // write to s0 completes on grant, state stays IDLE
        step(); mst_req = 1'b1; mst_we = 1'b1; mst_addr = 32'h0000_FFFF; s0_gnt = 1'b1; #2;
        chk("wr_gnt", mst_gnt, 1);
        chk("wr_s0_req_top", s0_req, 1);
        step(); mst_req = 1'b0; mst_we = 1'b0; #2;
        chk("wr_after_rvalid", mst_rvalid, 0);
        chk("wr_after_gnt_idle", mst_gnt, 1);

        // mask boundary: just above s0 window is unmapped
        mst_addr = 32'h0001_0000; #1;
        chk("bnd_s0_req", s0_req, 0);
        chk("bnd_gnt_noreq", mst_gnt, 0);

        // back-to-back: s0 read, then s1 read granted in the s0 rvalid cycle
        step(); mst_req = 1'b1; mst_addr = 32'h0000_0020; #2;
        chk("bb_gnt0", mst_gnt, 1);
        step(); mst_addr = 32'h1000_FFFC; s1_gnt = 1'b1; #2;
        chk("bb_hold_gnt", mst_gnt, 0);
        chk("bb_hold_s1_req", s1_req, 0);
        step(); s0_rvalid = 1'b1; s0_rdata = 32'hAAAA_5555; #2;
        chk("bb_rvalid0", mst_rvalid, 1);
        chk("bb_rdata0", mst_rdata, 32'hAAAA_5555);
        chk("bb_gnt1", mst_gnt, 1);
        chk("bb_s1_req", s1_req, 1);
        step(); mst_req = 1'b0; s0_rvalid = 1'b0; s1_rvalid = 1'b1; s1_rdata = 32'h5555_AAAA; #2;
        chk("bb_rvalid1", mst_rvalid, 1);
        chk("bb_rdata1", mst_rdata, 32'h5555_AAAA);
        step(); s1_rvalid = 1'b0; s1_gnt = 1'b0; #2;
        chk("bb_idle_rvalid", mst_rvalid, 0);

`ifdef OBI_DEMUX_TIMEOUT_EN
        // s0 never answers: watchdog fires in the 16th wait cycle
        step(); mst_req = 1'b1; mst_addr = 32'h0000_0040; #2;
        chk("to_gnt", mst_gnt, 1);
        step(); mst_req = 1'b0;
        for (int i = 1; i < 16; i++) begin
            #2;
            chk("to_wait_rvalid", mst_rvalid, 0);
            step();
        end
        #2;
        chk("to_rvalid", mst_rvalid, 1);
        chk("to_rdata", mst_rdata, 32'hBAD0_0BAD);
        chk("to_pulse", timeout, 1);
        step(); s0_rvalid = 1'b1; s0_rdata = 32'h1111_2222; #2;
        chk("to_late_rvalid", mst_rvalid, 0);
        chk("to_pulse_clr", timeout, 0);
        step(); s0_rvalid = 1'b0;
`endif

        // reset mid-cycle in WAIT0 drops grant and request at once
        step(); mst_req = 1'b1; mst_addr = 32'h0000_0030; #2;
        chk("mr_gnt0", mst_gnt, 1);
        step(); s0_rvalid = 1'b1; s0_rdata = 32'h7777_0000; #2;
        chk("mr_pre_gnt", mst_gnt, 1);
        chk("mr_pre_s0_req", s0_req, 1);
        #1 rst_n = 1'b0; #1;
        chk("mr_gnt", mst_gnt, 0);
        chk("mr_s0_req", s0_req, 0);
        chk("mr_rvalid", mst_rvalid, 0);
        step(); mst_req = 1'b0; rst_n = 1'b1; #2;
        chk("mr_stale_rvalid", mst_rvalid, 0);
        chk("mr_stale_rdata", mst_rdata, 0);
        step(); s0_rvalid = 1'b0; #2;
        chk("mr_end_rvalid", mst_rvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/obi_demux_1_to_2.md
OBI_DEMUX_1_TO_2 -- requirements
Module: obi_demux_1_to_2

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- S0_BASE, 32'h0000_0000, slave-0 match value.
- S0_MASK, 32'hFFFF_0000, slave-0 match mask.
- S1_BASE, 32'h1000_0000, slave-1 match value.
- S1_MASK, 32'hFFFF_0000, slave-1 match mask.
- TIMEOUT_CYCLES, 16, read watchdog limit, range 2..255.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk_i, in, 1, single clock; all flops on its rising edge.
- rst_ni, in, 1, reset; asynchronous, active-low.
- mst_req_i / mst_gnt_o, in / out, 1 / 1, upstream master request and grant (fed by obi_mux shared port).
- mst_addr_i, mst_we_i, mst_be_i, mst_wdata_i, in, 32 / 1 / 4 / 32, upstream address-phase signals.
- mst_rvalid_o, mst_rdata_o, out, 1 / 32, upstream response.
- s0_req_o, s0_gnt_i, s0_addr_o, s0_we_o, s0_be_o, s0_wdata_o, s0_rvalid_i, s0_rdata_i; OBI slave-0 port; widths as the master port.
- s1_* identical to s0_*; OBI slave-1 port.
- decode_err_o, out, 1, one-cycle pulse when an unmapped read response is returned.
- timeout_o, out, 1, one-cycle pulse when a watchdog response is returned.

Function
REQ-003 Decode SHALL be hit0 = ((mst_addr_i & S0_MASK) == S0_BASE) and hit1 = ((mst_addr_i & S1_MASK) == S1_BASE); hit0 SHALL take precedence when both hit.
REQ-004 Address-phase signals SHALL be broadcast to both slaves, with sN_req_o = mst_req_i & hitN & avail (hit1 gated by ~hit0).
REQ-005 mst_gnt_o SHALL equal sN_gnt_i of the selected slave & avail; for unmapped addresses it SHALL equal mst_req_i & avail (the error sink grants immediately).
REQ-006 State machine states SHALL be IDLE, WAIT0, WAIT1, ERR.
REQ-007 avail SHALL be 1 in IDLE and ERR, and in WAITn only in the cycle sN_rvalid_i=1; this enables back-to-back reads.
REQ-008 On an accepted read (req & gnt & ~we), the next state SHALL be WAIT0 / WAIT1 / ERR per decode.
REQ-009 In all other cases where avail=1, the next state SHALL be IDLE.
REQ-010 Writes SHALL complete on grant, with no response phase and no state change other than REQ-009.
REQ-011 In WAITn, mst_rvalid_o/mst_rdata_o SHALL equal sN_rvalid_i/sN_rdata_i. The other slave's rvalid SHALL be ignored in every state.
REQ-012 In ERR, the block SHALL drive mst_rvalid_o=1 and mst_rdata_o=32'h0 for exactly one cycle and pulse decode_err_o; read latency for unmapped reads is exactly 1 cycle.
REQ-013 In IDLE, mst_rvalid_o SHALL be 0 and mst_rdata_o SHALL be 32'h0.
REQ-014 At most one read SHALL be outstanding; mst_gnt_o SHALL be held 0 while in WAITn without rvalid.

Reset
REQ-015 Asserting rst_ni low SHALL force state to IDLE and clear the watchdog counter immediately, without waiting for a clock edge.
REQ-016 While rst_ni is low, mst_gnt_o, s0_req_o, s1_req_o, mst_rvalid_o, decode_err_o and timeout_o SHALL be 0, and mst_rdata_o SHALL be 32'h0.
REQ-017 A read outstanding when reset asserts SHALL be abandoned; a slave rvalid arriving after reset deasserts SHALL be ignored.

Configuration
REQ-018 With macro OBI_DEMUX_TIMEOUT_EN defined:
- An 8-bit counter SHALL clear on entering WAITn and increment each WAITn cycle without rvalid.
- When the count reaches TIMEOUT_CYCLES-1 with no rvalid, the block SHALL return mst_rvalid_o=1 with mst_rdata_o=32'hBAD0_0BAD and pulse timeout_o.
- State SHALL then go to IDLE; a late slave rvalid SHALL then be ignored.
- Without the macro, the block SHALL have no counter, timeout_o SHALL be tied 0, and WAITn SHALL wait indefinitely.

Verification
REQ-019 Read 0x0000_0010, s0_gnt_i=1, s0 rvalid 3 cycles later with 0x1234_5678 -> s1_req_o=0 throughout; mst_rdata_o=0x1234_5678 with mst_rvalid_o=1 for one cycle.
REQ-020 Read 0x1000_0004 with s1_gnt_i=0 for 2 cycles then 1 -> mst_gnt_o mirrors s1_gnt_i; state enters WAIT1 only after grant.
REQ-021 Read 0x2000_0000 -> mst_gnt_o=1 same cycle; next cycle mst_rvalid_o=1, mst_rdata_o=0, decode_err_o=1.
REQ-022 Back-to-back reads: s0 then s1 request issued in the s0 rvalid cycle -> second grant in that same cycle; no idle cycle between the two.
REQ-023 With OBI_DEMUX_TIMEOUT_EN, s0 never responds -> after 16 wait cycles mst_rdata_o=0xBAD0_0BAD and timeout_o=1; a late s0 rvalid is not forwarded.
REQ-024 rst_ni asserted low in WAIT0 mid-cycle -> mst_gnt_o and s0_req_o drop to 0 immediately; after release, a stale s0 rvalid produces no mst_rvalid_o.
